// File: rtl/frame_grab_ctrl.sv
// frame_grab_ctrl
// ---------------
// Command-driven sequencer for the camera-to-UART capture path (12 MHz clk).
// It decodes single-byte UART commands and gates the pixel FIFO write side to
// whole frames, using a synchronised frame-valid. It then frames the FIFO
// output for the UART transmitter as:
//   SYNC_BYTE, frame_cnt, pixel bytes..., byte_cnt[7:0], byte_cnt[15:8]
//
// Handshakes:
//   cmd_valid is a one-cycle strobe that qualifies cmd_data.
//   tx_valid is a one-cycle send strobe, raised only while tx_ready is high.
//     After a strobe, at least two low cycles follow, because the UART
//     empty flag reacts with latency.
//   px_ready pops the FIFO. It is only high together with tx_valid while
//     px_valid is high, so each popped byte is the byte sent in that cycle.
//
// Ports:
//   clk, resetn             system clock, synchronous active-low reset
//   cmd_data/cmd_valid      UART receive byte and strobe
//                           ('c' single, 's' stream, 'x' stop)
//   fv_async                raw frame-valid from the pixel clock domain
//   px_data/px_valid        FIFO read data / FIFO not empty
//   px_ready                FIFO pop
//   capture_en              FIFO write gate, high from sof through eof
//   tx_data/tx_valid        byte and strobe to the UART
//   tx_ready                UART idle
//   busy                    high whenever the sequencer is not idle
//   err                     sticky timeout flag for the wait for start of frame
//   frame_cnt               completed frames, wraps 255 -> 0
module frame_grab_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned DRAIN_IDLE     = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  input  logic       fv_async,
  input  logic [7:0] px_data,
  input  logic       px_valid,
  output logic       px_ready,
  output logic       capture_en,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err,
  output logic [7:0] frame_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_IDLE + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_HDR0 = 3'd2,
    S_HDR1 = 3'd3,
    S_XFER = 3'd4,
    S_TRL0 = 3'd5,
    S_TRL1 = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            fv_s1_q, fv_s2_q, fv_prev_q;
  logic            capture_en_q, capture_en_d;
  logic            err_q, err_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      gap_q, gap_d;
  logic [DW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            eof_seen_q, eof_seen_d;
  logic            stream_q, stream_d;
  logic            stop_pend_q, stop_pend_d;

  logic cmd_go, cmd_stop, sof, eof, slot_free, in_frame;

  assign cmd_go    = cmd_valid && ((cmd_data == 8'h63) || (cmd_data == 8'h73));
  assign cmd_stop  = cmd_valid && (cmd_data == 8'h78);
  // fv_prev_q follows the synchronised value in every state. An ARM entered
  // while fv is already high therefore only reacts to the next real rise.
  assign sof       = fv_s2_q && !fv_prev_q;
  assign eof       = !fv_s2_q && fv_prev_q;
  assign slot_free = (gap_q == 2'd0) && tx_ready;
  assign in_frame  = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_XFER);

  assign busy       = (state_q != S_IDLE);
  assign capture_en = capture_en_q;
  assign err        = err_q;
  assign frame_cnt  = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      fv_s1_q      <= 1'b0;
      fv_s2_q      <= 1'b0;
      fv_prev_q    <= 1'b0;
      capture_en_q <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= 8'd0;
      byte_cnt_q   <= 16'd0;
      timer_q      <= '0;
      gap_q        <= 2'd0;
      idle_cnt_q   <= '0;
      eof_seen_q   <= 1'b0;
      stream_q     <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fv_s1_q      <= fv_async;
      fv_s2_q      <= fv_s1_q;
      fv_prev_q    <= fv_s2_q;
      capture_en_q <= capture_en_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      idle_cnt_q   <= idle_cnt_d;
      eof_seen_q   <= eof_seen_d;
      stream_q     <= stream_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    capture_en_d = capture_en_q;
    err_d        = err_q;
    frame_cnt_d  = frame_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    gap_d        = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
    idle_cnt_d   = idle_cnt_q;
    eof_seen_d   = eof_seen_q;
    stream_d     = stream_q;
    stop_pend_d  = stop_pend_q;
    tx_valid     = 1'b0;
    tx_data      = 8'd0;
    px_ready     = 1'b0;

    // The end of frame is tracked in the header states too, so that a very
    // short frame whose eof lands before XFER still closes capture.
    // The idle counter starts only after eof and saturates at its final value.
    if (in_frame) begin
      if (eof) begin
        capture_en_d = 1'b0;
        eof_seen_d   = 1'b1;
        idle_cnt_d   = '0;
      end else if (eof_seen_q) begin
        if (px_valid)                      idle_cnt_d = '0;
        else if (idle_cnt_q != DRAIN_LAST) idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end

    if (cmd_stop && (state_q != S_IDLE) && (state_q != S_ARM)) stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_go) begin
          state_d     = S_ARM;
          err_d       = 1'b0;
          timer_d     = '0;
          stream_d    = (cmd_data == 8'h73);
          stop_pend_d = 1'b0;
        end
      end
      S_ARM: begin
        if (cmd_stop) begin
          capture_en_d = 1'b0;
          state_d      = S_IDLE;
        end else if (sof) begin
          capture_en_d = 1'b1;
          byte_cnt_d   = 16'd0;
          eof_seen_d   = 1'b0;
          idle_cnt_d   = '0;
          state_d      = S_HDR0;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_HDR0: begin
        if (slot_free) begin
          tx_valid = 1'b1;
          tx_data  = SYNC_BYTE;
          gap_d    = 2'd2;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (slot_free) begin
          tx_valid = 1'b1;
          tx_data  = frame_cnt_q;
          gap_d    = 2'd2;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        if (slot_free && px_valid) begin
          tx_valid   = 1'b1;
          tx_data    = px_data;
          px_ready   = 1'b1;
          gap_d      = 2'd2;
          byte_cnt_d = byte_cnt_q + 16'd1;
        end
        // Drained once the current cycle is the DRAIN_IDLE-th consecutive
        // empty cycle after eof.
        if (eof_seen_q && !eof && !px_valid && (idle_cnt_q == DRAIN_LAST)) begin
          state_d = S_TRL0;
        end
      end
      S_TRL0: begin
        if (slot_free) begin
          tx_valid = 1'b1;
          tx_data  = byte_cnt_q[7:0];
          gap_d    = 2'd2;
          state_d  = S_TRL1;
        end
      end
      S_TRL1: begin
        if (slot_free) begin
          tx_valid    = 1'b1;
          tx_data     = byte_cnt_q[15:8];
          gap_d       = 2'd2;
          frame_cnt_d = frame_cnt_q + 8'd1;
          eof_seen_d  = 1'b0;
          if (stream_q && !stop_pend_q && !cmd_stop) begin
            state_d = S_ARM;
            timer_d = '0;
          end else begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_grab_ctrl.sv
// Bench for frame_grab_ctrl.
// The reference model is a stream-level view: every captured frame must
// appear on the UART as A5, frame index, the bytes written during the frame,
// then the 16-bit length, low byte first. The pixel FIFO is a queue. Bytes
// are written only well inside the fv pulse, so the expected content follows
// from the stimulus alone.
module tb_frame_grab_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       fv_async;
  logic [7:0] px_data;
  logic       px_valid;
  logic       px_ready;
  logic       capture_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       err;
  logic [7:0] frame_cnt;

  frame_grab_ctrl #(
    .TIMEOUT_CYCLES(1000),
    .SYNC_BYTE     (8'hA5),
    .DRAIN_IDLE    (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .fv_async  (fv_async),
    .px_data   (px_data),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .capture_en(capture_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         last_tx = -100;
  logic [7:0] exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] fcnt_m = 8'd0;
  bit         pop_flag = 1'b0;
  bit         stall = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // FIFO read side: the pop seen in a cycle is applied just after its edge.
  assign px_valid = (fifo_q.size() != 0);
  assign px_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;

  always @(posedge clk) begin
    #1;
    if (pop_flag && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_flag = 1'b0;
  end

  // UART idle flag: mostly ready, random short busy periods, forced low in a stall.
  always @(posedge clk) begin
    #2;
    tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      last_tx = -100;
    end else begin
      if (tx_valid) begin
        check("tx_needs_ready", tx_ready, 1'b1);
        check("tx_spacing", (cyc - last_tx) >= 3, 1'b1);
        if (exp_q.size() == 0) check("tx_unexpected", exp_q.size(), 1);
        else                   check("tx_data", tx_data, exp_q.pop_front());
        last_tx = cyc;
      end
      if (px_ready) begin
        check("px_ready_with_tx", tx_valid, 1'b1);
        pop_flag = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  // One fv pulse carrying n bytes. stop_at/stall_at/reset_at are byte indices
  // at which an 'x', a 50-cycle tx_ready stall or a one-cycle reset happens
  // (-1 = never).
  task automatic run_frame(input int n, input bit seq, input int stop_at,
                           input int stall_at, input int reset_at);
    logic [7:0]  b;
    logic [15:0] len;
    int          t;
    exp_q.push_back(8'hA5);
    exp_q.push_back(fcnt_m);
    fv_async = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < n; i++) begin
      if (i == reset_at) begin
        resetn = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        fcnt_m = 8'd0;
        tick();
        resetn   = 1'b1;
        fv_async = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_cap", capture_en, 1'b0);
        check("rst_txv", tx_valid, 1'b0);
        check("rst_pxr", px_ready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_fcnt", frame_cnt, 8'd0);
        tick();
        return;
      end
      if (i == stop_at) send_cmd(8'h78);
      if (i == stall_at) begin
        stall = 1'b1;
        repeat (50) tick();
        stall = 1'b0;
      end
      b = seq ? i[7:0] : 8'($urandom_range(0, 255));
      check("capture_en_in_frame", capture_en, 1'b1);
      fifo_q.push_back(b);
      exp_q.push_back(b);
      repeat ($urandom_range(1, 3)) tick();
    end
    repeat (2) tick();
    fv_async = 1'b0;
    len = 16'(n);
    exp_q.push_back(len[7:0]);
    exp_q.push_back(len[15:8]);
    fcnt_m = fcnt_m + 8'd1;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      tick();
      t++;
    end
    check("frame_drained", exp_q.size(), 0);
    @(negedge clk);
    check("frame_cnt", frame_cnt, fcnt_m);
    check("capture_en_after", capture_en, 1'b0);
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    resetn    = 1'b0;
    cmd_data  = 8'h00;
    cmd_valid = 1'b0;
    fv_async  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_cap", capture_en, 1'b0);
    check("reset_txv", tx_valid, 1'b0);
    check("reset_pxr", px_ready, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_fcnt", frame_cnt, 8'd0);
    tick();
    resetn = 1'b1;
    repeat (3) tick();

    // Single frame, bytes 0x00..0x63.
    send_cmd(8'h63);
    run_frame(100, 1'b1, -1, -1, -1);
    check("single_busy", busy, 1'b0);

    // Stream of three 4-byte frames, stop during the third.
    send_cmd(8'h73);
    run_frame(4, 1'b0, -1, -1, -1);
    check("stream_busy", busy, 1'b1);
    run_frame(4, 1'b0, -1, -1, -1);
    run_frame(4, 1'b0, 2, -1, -1);
    check("stop_busy", busy, 1'b0);
    check("stop_fcnt", frame_cnt, 8'd4);

    // Timeout while waiting for the start of frame.
    send_cmd(8'h63);
    repeat (999) tick();
    @(negedge clk);
    check("arm_err_early", err, 1'b0);
    check("arm_busy_early", busy, 1'b1);
    tick();
    @(negedge clk);
    check("timeout_err", err, 1'b1);
    check("timeout_busy", busy, 1'b0);
    tick();
    send_cmd(8'h63);
    @(negedge clk);
    check("err_cleared", err, 1'b0);
    tick();
    send_cmd(8'h78);
    @(negedge clk);
    check("stop_in_arm", busy, 1'b0);
    tick();

    // Arming while fv is already high: that frame must be skipped.
    fv_async = 1'b1;
    repeat (6) tick();
    send_cmd(8'h63);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("partial_cap_off", capture_en, 1'b0);
      tick();
    end
    fv_async = 1'b0;
    repeat (5) tick();
    run_frame(10, 1'b0, -1, -1, -1);

    // 50-cycle UART stall in mid-frame.
    send_cmd(8'h63);
    run_frame(30, 1'b0, -1, 10, -1);

    // Random lengths including the empty and single-byte frames.
    for (int k = 0; k < 4; k++) begin
      send_cmd(8'h63);
      run_frame((k == 0) ? 0 : (k == 1) ? 1 : int'($urandom_range(2, 40)),
                1'b0, -1, -1, -1);
      check("rand_busy", busy, 1'b0);
    end

    // Reset in mid-frame, then stray commands, then a normal frame.
    send_cmd(8'h63);
    run_frame(20, 1'b0, -1, -1, 5);
    send_cmd(8'h78);
    send_cmd(8'h71);
    repeat (4) tick();
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_fcnt", frame_cnt, 8'd0);
    check("post_rst_cap", capture_en, 1'b0);
    tick();
    send_cmd(8'h63);
    run_frame(12, 1'b0, -1, -1, -1);
    check("final_busy", busy, 1'b0);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_grab_ctrl.md
Name: frame_grab_ctrl

Overview:
Command-driven sequencer for the camera-to-UART capture path, on the 12 MHz system clock. It decodes single-byte commands from the UART receiver and gates the pixel FIFO write enable to whole frames using a synchronised frame-valid. It then frames the FIFO output for the UART transmitter as header, pixel bytes and trailer. It replaces the ad-hoc load_fifo/state logic in the top level.

Parameters:
TIMEOUT_CYCLES, 12000000, cycles allowed in ARM waiting for start of frame before error (1 s at 12 MHz).
SYNC_BYTE, 8'hA5, first header byte of every frame.
DRAIN_IDLE, 8, consecutive cycles with px_valid low after EOF that declare the FIFO drained.

Ports:
clk  input  1  system clock (12 MHz)
resetn  input  1  synchronous reset, active-low
cmd_data  input  8  UART receive byte
cmd_valid  input  1  one-cycle strobe qualifying cmd_data
fv_async  input  1  raw px_fv from the px_clk domain (asynchronous)
px_data  input  8  FIFO read data
px_valid  input  1  FIFO read side not empty
px_ready  output  1  FIFO pop; high only in a cycle where a pixel is sent
capture_en  output  1  FIFO write gate (ANDed with pixel valid in px_clk domain)
tx_data  output  8  byte to UART
tx_valid  output  1  one-cycle send strobe
tx_ready  input  1  UART idle (o_empty)
busy  output  1  high in any state other than IDLE
err  output  1  sticky ARM timeout flag; cleared by the next accepted 'c' or 's'
frame_cnt  output  8  frames completed, wraps 255->0

Behaviour:
- Reset (resetn=0 at a clk edge) clears all outputs, counters, sync flops and mode flags to 0 and forces state to IDLE. A reset mid-frame abandons the frame and sends no trailer.
- fv_async passes through a 2-flop synchroniser.
  - sof = rising edge of the synced value.
  - eof = falling edge of the synced value.
  - Each is a one-cycle pulse, 3 cycles after the input edge.
- Commands, accepted only on cmd_valid:
  - 0x63 'c': single frame, accepted in IDLE only.
  - 0x73 's': stream, accepted in IDLE only.
  - 0x78 'x': stop, any state.
  - All other bytes, and 'c'/'s' outside IDLE, are ignored.
- States:
  - IDLE: on 'c' or 's' go to ARM. Clear err and timer; latch stream mode.
  - ARM: timer counts each cycle.
    - On sof: capture_en<=1, clear byte_cnt, go to HDR0.
    - When timer reaches TIMEOUT_CYCLES-1 with no sof: err<=1, go to IDLE.
    - If ARM is entered while the synced fv is already high, wait for the next rising edge; partial frames are never captured.
  - HDR0: send SYNC_BYTE, then go to HDR1.
  - HDR1: send frame_cnt, then go to XFER.
  - XFER: when px_valid and a send slot is free, send px_data with px_ready=1 in the same cycle, and byte_cnt+=1 (16-bit, wraps).
    - On eof: capture_en<=0 and set eof_seen.
    - If sof and eof occur in the same cycle, eof takes priority.
    - When eof_seen and px_valid has been low for DRAIN_IDLE consecutive cycles, go to TRL0.
  - TRL0: send byte_cnt[7:0], then go to TRL1.
  - TRL1: send byte_cnt[15:8]. Then frame_cnt+=1 and clear eof_seen.
    - Go to ARM if stream mode is set and no stop is pending; otherwise go to IDLE.
- Stop ('x'):
  - In ARM: capture_en=0 and go to IDLE immediately, with no header or trailer.
  - In HDR/XFER/TRL: set stop_pending; the current frame completes including its trailer, then go to IDLE.
  - In IDLE: no effect.
- Send slot:
  - tx_valid is a single-cycle pulse, issued only when tx_ready=1 in that cycle.
  - After any pulse, tx_valid is held low for at least 2 cycles (UART empty-flag latency) before the next slot.
  - tx_data is valid in the cycle tx_valid is high.
- px_ready is never high outside XFER and never high without tx_valid.
- capture_en is high only from the sof cycle through the eof cycle of one frame.

Test Plan:
- 'c' (0x63), fv pulse with 100 FIFO bytes 0x00..0x63 → UART sequence A5, 00, 00..63, 64, 00; frame_cnt=1; busy falls after the last byte; capture_en low.
- 's', three fv pulses of 4 bytes each → three frames with header bytes A5,00 / A5,01 / A5,02, each trailer 04,00. Then 'x' mid-frame 3 → frame 3 completes, IDLE, frame_cnt=3.
- 'c' with fv held low, TIMEOUT_CYCLES=1000 → err=1 at cycle 1000 after ARM entry; IDLE; no tx_valid. A following 'c' clears err.
- 'c' while fv already high → no capture until the next fv rise; bytes present before that rise are not popped.
- tx_ready held low for 50 cycles mid-XFER → no tx_valid and no px_ready during the stall; resume with no loss or duplicate; tx_valid pulses ≥3 cycles apart.
- 'c' then resetn=0 for 1 cycle mid-XFER → all outputs 0 the next cycle; a following 'x' and 'q' (0x71) have no effect; a following 'c' works normally.
